rana_position_ctrl: RTL and testbench

Parametrised frog controller for the Frogger game: turns the four direction buttons into a frog position on a ROWS×COLS LED grid. Supports auto-repeat on held buttons and optional column wrap-around. Detects collision against the hazard map from the lane blocks and tracks goal arrival and lives. Drives the one-hot frog layer that the display mixer ORs with the lane layers.

---
 rtl/rana_position_ctrl_if.sv | 30 +++
 rtl/rana_position_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rana_position_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rana_position_ctrl_if.sv
// Frog controller bus: debounced buttons and hazard map in, frog layer and game status out.
interface rana_position_ctrl_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                      Rana_Up;
    logic                      Rana_Down;
    logic                      Rana_Left;
    logic                      Rana_Right;
    logic [ROWS*COLS-1:0]      Rana_Hazard_Map;
    logic [ROWS*COLS-1:0]      Rana_Led_Map_Bus;
    logic [$clog2(ROWS)-1:0]   Rana_Row;
    logic [$clog2(COLS)-1:0]   Rana_Col;
    logic [2:0]                Rana_Lives;
    logic                      Rana_Win;
    logic                      Rana_Dead;
    logic                      Rana_Game_Over;

    modport master (
        output Rana_Up, Rana_Down, Rana_Left, Rana_Right, Rana_Hazard_Map,
        input  Rana_Led_Map_Bus, Rana_Row, Rana_Col, Rana_Lives,
               Rana_Win, Rana_Dead, Rana_Game_Over
    );

    modport slave (
        input  Rana_Up, Rana_Down, Rana_Left, Rana_Right, Rana_Hazard_Map,
        output Rana_Led_Map_Bus, Rana_Row, Rana_Col, Rana_Lives,
               Rana_Win, Rana_Dead, Rana_Game_Over
    );
endinterface

// File: rtl/rana_position_ctrl.sv
// Frogger frog controller: button moves with auto-repeat, collision/goal detection,
// lives tracking and respawn dwell. All outputs come straight from registers.
module rana_position_ctrl #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int START_COL      = COLS/2-1,
    parameter int LIVES          = 3,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int RESPAWN_CYCLES = 50_000_000,
    parameter int WRAP_COLS      = 0
) (
    input  logic                  Rana_CLOCK_50,
    input  logic                  Rana_Reset,
    rana_position_ctrl_if.slave   bus
);
    // state | meaning
    // PLAY  | frog accepts moves, hazards checked
    // WIN   | goal reached, dwelling before respawn
    // DEAD  | collision, dwelling before respawn or game over
    // OVER  | no lives left, frozen until reset
    typedef enum logic [1:0] {S_PLAY, S_WIN, S_DEAD, S_OVER} state_t;

    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int N    = ROWS*COLS;
    localparam int PW   = $clog2(N);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX+1);
    localparam int DW   = $clog2(RESPAWN_CYCLES+1);

    state_t         r_state, w_state_nxt;
    logic [RW-1:0]  r_row, w_row_nxt;
    logic [CW-1:0]  r_col, w_col_nxt;
    logic [N-1:0]   r_led, w_led_nxt;
    logic [2:0]     r_lives, w_lives_nxt;
    logic           r_win, w_win_nxt;
    logic           r_dead, w_dead_nxt;
    logic           r_goal, w_goal_nxt;
    logic [3:0]     r_btn_prev;
    logic [TW-1:0]  r_rpt, w_rpt_nxt;
    logic           r_rpt_act, w_rpt_act_nxt;
    logic [DW-1:0]  r_dwell, w_dwell_nxt;

    logic [3:0]     w_btn;
    logic           w_single, w_press, w_hold, w_move;
    logic [PW-1:0]  w_idx, w_idx_nxt;

    assign w_btn     = {bus.Rana_Up, bus.Rana_Down, bus.Rana_Left, bus.Rana_Right};
    assign w_single  = $onehot(w_btn);
    assign w_press   = w_single && ((w_btn & r_btn_prev) == 4'b0000);
    assign w_hold    = w_single && (w_btn == r_btn_prev) && r_rpt_act;
    assign w_idx     = PW'(r_row) * PW'(COLS) + PW'(r_col);
    assign w_idx_nxt = PW'(w_row_nxt) * PW'(COLS) + PW'(w_col_nxt);
    assign w_led_nxt = N'(1) << w_idx_nxt;

    always_ff @(posedge Rana_CLOCK_50 or negedge Rana_Reset) begin
        if (!Rana_Reset) begin
            r_state    <= S_PLAY;
            r_row      <= '0;
            r_col      <= CW'(START_COL);
            r_led      <= N'(1) << START_COL;
            r_lives    <= 3'(LIVES);
            r_win      <= 1'b0;
            r_dead     <= 1'b0;
            r_goal     <= 1'b0;
            r_btn_prev <= 4'b0000;
            r_rpt      <= '0;
            r_rpt_act  <= 1'b0;
            r_dwell    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_led      <= w_led_nxt;
            r_lives    <= w_lives_nxt;
            r_win      <= w_win_nxt;
            r_dead     <= w_dead_nxt;
            r_goal     <= w_goal_nxt;
            r_btn_prev <= w_btn;
            r_rpt      <= w_rpt_nxt;
            r_rpt_act  <= w_rpt_act_nxt;
            r_dwell    <= w_dwell_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_lives_nxt   = r_lives;
        w_win_nxt     = 1'b0;
        w_dead_nxt    = 1'b0;
        w_goal_nxt    = 1'b0;
        w_rpt_nxt     = '0;
        w_rpt_act_nxt = 1'b0;
        w_dwell_nxt   = r_dwell;
        w_move        = 1'b0;
        case (r_state)
            S_PLAY: begin
                // A pending goal wins over everything; the frog has already arrived.
                if (r_goal) begin
                    w_win_nxt   = 1'b1;
                    w_state_nxt = S_WIN;
                    w_dwell_nxt = DW'(RESPAWN_CYCLES-1);
                end else if (bus.Rana_Hazard_Map[w_idx]) begin
                    w_lives_nxt = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;
                    w_dead_nxt  = 1'b1;
                    w_state_nxt = S_DEAD;
                    w_dwell_nxt = DW'(RESPAWN_CYCLES-1);
                end else begin
                    if (w_press) begin
                        w_move        = 1'b1;
                        w_rpt_nxt     = TW'(HOLD_CYCLES-1);
                        w_rpt_act_nxt = 1'b1;
                    end else if (w_hold) begin
                        w_rpt_act_nxt = 1'b1;
                        if (r_rpt == '0) begin
                            w_move    = 1'b1;
                            w_rpt_nxt = TW'(REPEAT_CYCLES-1);
                        end else begin
                            w_rpt_nxt = r_rpt - TW'(1);
                        end
                    end
                    if (w_move) begin
                        case (w_btn)
                            4'b1000: if (r_row != RW'(ROWS-1)) w_row_nxt = r_row + RW'(1);
                            4'b0100: if (r_row != '0) w_row_nxt = r_row - RW'(1);
                            4'b0010: begin
                                if (r_col != '0)         w_col_nxt = r_col - CW'(1);
                                else if (WRAP_COLS != 0) w_col_nxt = CW'(COLS-1);
                            end
                            4'b0001: begin
                                if (r_col != CW'(COLS-1)) w_col_nxt = r_col + CW'(1);
                                else if (WRAP_COLS != 0)  w_col_nxt = '0;
                            end
                            default: ;
                        endcase
                    end
                    w_goal_nxt = w_move && (w_row_nxt == RW'(ROWS-1));
                end
            end
            S_WIN, S_DEAD: begin
                if (r_dwell == '0) begin
                    if (r_state == S_DEAD && r_lives == 3'd0) begin
                        w_state_nxt = S_OVER;
                    end else begin
                        w_state_nxt = S_PLAY;
                        w_row_nxt   = '0;
                        w_col_nxt   = CW'(START_COL);
                    end
                end else begin
                    w_dwell_nxt = r_dwell - DW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.Rana_Led_Map_Bus = r_led;
    assign bus.Rana_Row         = r_row;
    assign bus.Rana_Col         = r_col;
    assign bus.Rana_Lives       = r_lives;
    assign bus.Rana_Win         = r_win;
    assign bus.Rana_Dead        = r_dead;
    assign bus.Rana_Game_Over   = (r_state == S_OVER);
endmodule

// File: tb/tb_rana_position_ctrl.sv
// Bench for rana_position_ctrl: directed vector table, reset corner cases, and random
// stimulus against a cycle-level game model, on a saturating and a wrapping instance.
module tb_rana_position_ctrl;
    localparam int HOLD = 4;
    localparam int REP  = 2;
    localparam int RESP = 5;
    localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001;
    localparam int MP = 0, MW = 1, MD = 2, MO = 3;

    logic        clk = 1'b0;
    logic        t_rst;
    logic [3:0]  t_btn;
    logic [63:0] t_haz;
    bit          chk_en;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rana_position_ctrl_if #(.ROWS(8), .COLS(8)) bus0 ();
    rana_position_ctrl_if #(.ROWS(8), .COLS(8)) bus1 ();

    assign {bus0.Rana_Up, bus0.Rana_Down, bus0.Rana_Left, bus0.Rana_Right} = t_btn;
    assign {bus1.Rana_Up, bus1.Rana_Down, bus1.Rana_Left, bus1.Rana_Right} = t_btn;
    assign bus0.Rana_Hazard_Map = t_haz;
    assign bus1.Rana_Hazard_Map = t_haz;

    rana_position_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .RESPAWN_CYCLES(RESP),
                         .WRAP_COLS(0)) dut0 (.Rana_CLOCK_50(clk), .Rana_Reset(t_rst), .bus(bus0));
    rana_position_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .RESPAWN_CYCLES(RESP),
                         .WRAP_COLS(1)) dut1 (.Rana_CLOCK_50(clk), .Rana_Reset(t_rst), .bus(bus1));

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Game model: cycles-since-press and elapsed-dwell up-counters, plain integer positions.
    int          m_row[2], m_col[2], m_lives[2], m_mode[2], m_held[2], m_dwell[2];
    bit          m_win[2], m_dead[2], m_goal[2];
    logic [3:0]  m_prev[2];

    task automatic mreset(int w);
        m_row[w] = 0; m_col[w] = 3; m_lives[w] = 3; m_mode[w] = MP; m_held[w] = -1;
        m_dwell[w] = 0; m_win[w] = 0; m_dead[w] = 0; m_goal[w] = 0; m_prev[w] = 4'b0;
    endtask

    task automatic mstep(int w, logic [3:0] b, logic [63:0] hz);
        bit mv;
        m_win[w] = 0;
        m_dead[w] = 0;
        case (m_mode[w])
            MP: begin
                if (m_goal[w]) begin
                    m_goal[w] = 0; m_win[w] = 1; m_mode[w] = MW; m_dwell[w] = 0; m_held[w] = -1;
                end else if (hz[m_row[w]*8 + m_col[w]]) begin
                    if (m_lives[w] > 0) m_lives[w]--;
                    m_dead[w] = 1; m_mode[w] = MD; m_dwell[w] = 0; m_held[w] = -1;
                end else begin
                    mv = 0;
                    if ($countones(b) == 1 && (b & m_prev[w]) == 4'b0) begin
                        mv = 1; m_held[w] = 0;
                    end else if ($countones(b) == 1 && b == m_prev[w] && m_held[w] >= 0) begin
                        m_held[w]++;
                        mv = (m_held[w] == HOLD) || (m_held[w] > HOLD && (m_held[w]-HOLD) % REP == 0);
                    end else begin
                        m_held[w] = -1;
                    end
                    if (mv) begin
                        if (b[3] && m_row[w] < 7) m_row[w]++;
                        if (b[2] && m_row[w] > 0) m_row[w]--;
                        if (b[1]) m_col[w] = (m_col[w] > 0) ? m_col[w]-1 : (w == 1 ? 7 : 0);
                        if (b[0]) m_col[w] = (m_col[w] < 7) ? m_col[w]+1 : (w == 1 ? 0 : 7);
                        if (m_row[w] == 7) m_goal[w] = 1;
                    end
                end
            end
            MW, MD: begin
                m_dwell[w]++;
                if (m_dwell[w] == RESP) begin
                    if (m_mode[w] == MD && m_lives[w] == 0) m_mode[w] = MO;
                    else begin m_mode[w] = MP; m_row[w] = 0; m_col[w] = 3; m_held[w] = -1; end
                end
            end
            default: ;
        endcase
        m_prev[w] = b;
    endtask

    always @(posedge clk or negedge t_rst) begin
        if (!t_rst) begin mreset(0); mreset(1); end
        else begin mstep(0, t_btn, t_haz); mstep(1, t_btn, t_haz); end
    end

    task automatic mcmp(int w, logic [2:0] row, logic [2:0] col, logic [2:0] lives,
                        logic win, logic dead, logic over, logic [63:0] led);
        string p;
        p = (w == 0) ? "sat" : "wrap";
        chk({p, "_row"},   row,   m_row[w]);
        chk({p, "_col"},   col,   m_col[w]);
        chk({p, "_lives"}, lives, m_lives[w]);
        chk({p, "_win"},   win,   m_win[w]);
        chk({p, "_dead"},  dead,  m_dead[w]);
        chk({p, "_over"},  over,  m_mode[w] == MO);
        chk({p, "_led"},   led,   64'(1) << (m_row[w]*8 + m_col[w]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            mcmp(0, bus0.Rana_Row, bus0.Rana_Col, bus0.Rana_Lives, bus0.Rana_Win,
                 bus0.Rana_Dead, bus0.Rana_Game_Over, bus0.Rana_Led_Map_Bus);
            mcmp(1, bus1.Rana_Row, bus1.Rana_Col, bus1.Rana_Lives, bus1.Rana_Win,
                 bus1.Rana_Dead, bus1.Rana_Game_Over, bus1.Rana_Led_Map_Bus);
        end
    end

    typedef struct {
        logic [3:0]  btn;
        logic [63:0] haz;
        int          row, col, wcol, lives;
        bit          win, dead, over;
    } vec_t;
    vec_t vq[$];

    function automatic void add(logic [3:0] b, logic [63:0] h, int r, int c, int wc, int l,
                                bit wi, bit d, bit o);
        vec_t v;
        v.btn = b; v.haz = h; v.row = r; v.col = c; v.wcol = wc; v.lives = l;
        v.win = wi; v.dead = d; v.over = o;
        vq.push_back(v);
    endfunction

    task automatic chk_now(string tag, int row, int col, int lives, bit win, bit dead, bit over);
        chk({tag, "_row"},   bus0.Rana_Row, row);
        chk({tag, "_col"},   bus0.Rana_Col, col);
        chk({tag, "_lives"}, bus0.Rana_Lives, lives);
        chk({tag, "_win"},   bus0.Rana_Win, win);
        chk({tag, "_dead"},  bus0.Rana_Dead, dead);
        chk({tag, "_over"},  bus0.Rana_Game_Over, over);
        chk({tag, "_led"},   bus0.Rana_Led_Map_Bus, 64'(1) << (row*8 + col));
    endtask

    initial begin
        int r;
        t_rst = 1'b0; t_btn = 4'b0; t_haz = 64'h0; chk_en = 0;

        add(0, 0, 0, 3, 3, 3, 0, 0, 0);
        add(R, 0, 0, 4, 4, 3, 0, 0, 0);
        add(0, 0, 0, 4, 4, 3, 0, 0, 0);
        repeat (4) add(U, 0, 1, 4, 4, 3, 0, 0, 0);
        for (int rw = 2; rw <= 6; rw++) repeat (2) add(U, 0, rw, 4, 4, 3, 0, 0, 0);
        add(U, 0, 7, 4, 4, 3, 0, 0, 0);
        add(U, 0, 7, 4, 4, 3, 1, 0, 0);
        repeat (4) add(0, 0, 7, 4, 4, 3, 0, 0, 0);
        repeat (2) add(0, 0, 0, 3, 3, 3, 0, 0, 0);
        add(U, 0, 1, 3, 3, 3, 0, 0, 0);
        add(D, 0, 0, 3, 3, 3, 0, 0, 0);
        repeat (2) add(U | L, 0, 0, 3, 3, 3, 0, 0, 0);
        repeat (5) add(L, 0, 0, 3, 3, 3, 0, 0, 0);
        add(0, 0, 0, 3, 3, 3, 0, 0, 0);
        add(L, 0, 0, 2, 2, 3, 0, 0, 0);
        add(0, 0, 0, 2, 2, 3, 0, 0, 0);
        add(L, 0, 0, 1, 1, 3, 0, 0, 0);
        add(0, 0, 0, 1, 1, 3, 0, 0, 0);
        add(L, 0, 0, 0, 0, 3, 0, 0, 0);
        add(0, 0, 0, 0, 0, 3, 0, 0, 0);
        add(L, 0, 0, 0, 7, 3, 0, 0, 0);
        add(0, 0, 0, 0, 7, 3, 0, 0, 0);
        add(R, 64'h81, 0, 0, 7, 2, 0, 1, 0);
        repeat (4) add(0, 0, 0, 0, 7, 2, 0, 0, 0);
        add(0, 0, 0, 3, 3, 2, 0, 0, 0);
        add(0, 64'h8, 0, 3, 3, 1, 0, 1, 0);
        repeat (5) add(0, 64'h8, 0, 3, 3, 1, 0, 0, 0);
        add(0, 64'h8, 0, 3, 3, 0, 0, 1, 0);
        repeat (4) add(0, 64'h8, 0, 3, 3, 0, 0, 0, 0);
        add(0, 64'h8, 0, 3, 3, 0, 0, 0, 1);
        add(U, 64'h8, 0, 3, 3, 0, 0, 0, 1);
        add(R, 64'h8, 0, 3, 3, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        #1 chk_now("reset", 0, 3, 3, 0, 0, 0);
        t_rst = 1'b1;
        chk_en = 1;

        foreach (vq[i]) begin
            @(negedge clk);
            #1 t_btn = vq[i].btn; t_haz = vq[i].haz;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_row", i),   bus0.Rana_Row,   vq[i].row);
            chk($sformatf("v%0d_col", i),   bus0.Rana_Col,   vq[i].col);
            chk($sformatf("v%0d_wcol", i),  bus1.Rana_Col,   vq[i].wcol);
            chk($sformatf("v%0d_lives", i), bus0.Rana_Lives, vq[i].lives);
            chk($sformatf("v%0d_win", i),   bus0.Rana_Win,   vq[i].win);
            chk($sformatf("v%0d_dead", i),  bus0.Rana_Dead,  vq[i].dead);
            chk($sformatf("v%0d_over", i),  bus0.Rana_Game_Over, vq[i].over);
        end

        // Reset out of OVER, then reset again in the middle of a DEAD dwell.
        @(negedge clk);
        #1 t_rst = 1'b0; t_btn = 4'b0; t_haz = 64'h0;
        #1 chk_now("rst_over", 0, 3, 3, 0, 0, 0);
        @(negedge clk);
        #1 t_rst = 1'b1;
        @(negedge clk);
        #1 t_haz = 64'h8;
        @(posedge clk);
        #1 chk_now("hit", 0, 3, 2, 0, 1, 0);
        @(negedge clk);
        #1 t_haz = 64'h0; t_btn = R;
        @(posedge clk);
        #1 chk_now("dwell_btn", 0, 3, 2, 0, 0, 0);
        @(negedge clk);
        #1 t_rst = 1'b0;
        #1 chk_now("rst_dwell", 0, 3, 3, 0, 0, 0);
        @(posedge clk);
        #1 chk_now("rst_hold", 0, 3, 3, 0, 0, 0);
        @(negedge clk);
        #1 t_rst = 1'b1; t_btn = 4'b0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            t_rst = (c % 400 == 399) ? 1'b0 : 1'b1;
            r = $urandom_range(0, 9);
            if (r == 0)      t_btn = 4'($urandom_range(0, 15));
            else if (r < 3)  t_btn = 4'(1 << $urandom_range(0, 3));
            else if (r == 3) t_btn = 4'b0;
            t_haz = ($urandom_range(0, 24) == 0) ? {$urandom, $urandom} : 64'h0;
        end
        @(negedge clk);
        #1 chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
